// File: rtl/nn_accel_job_scheduler.sv
// Round-robin job scheduler for a mesh-attached NN accelerator.
// Grants one tile, writes three config packets, then awaits done or timeout.
module nn_accel_job_scheduler #(
  parameter int num_req_p      = 4,
  parameter int addr_width_p   = 10,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 2,
  parameter int timeout_p      = 1024
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*addr_width_p-1:0] req_src_addr_i,
  input  logic [num_req_p*addr_width_p-1:0] req_len_i,
  output logic [num_req_p-1:0]              req_ack_o,
  input  logic [x_cord_width_p-1:0]         dest_x_i,
  input  logic [y_cord_width_p-1:0]         dest_y_i,
  output logic                              pkt_v_o,
  input  logic                              pkt_ready_i,
  output logic [x_cord_width_p-1:0]         pkt_x_o,
  output logic [y_cord_width_p-1:0]         pkt_y_o,
  output logic [addr_width_p-1:0]           pkt_addr_o,
  output logic [data_width_p-1:0]           pkt_data_o,
  input  logic                              accel_done_i,
  output logic [num_req_p-1:0]              resp_v_o,
  output logic                              resp_err_o,
  output logic                              busy_o
);

  localparam int lg_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(timeout_p - 1);

  typedef enum logic [2:0] {
    IDLE, CFG_SRC, CFG_LEN, CFG_GO, BUSY, DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [lg_lp-1:0]         last_q, last_d;
  logic [lg_lp-1:0]         win_q, win_d;
  logic [addr_width_p-1:0]  src_q, src_d;
  logic [addr_width_p-1:0]  len_q, len_d;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [num_req_p-1:0]     ack_q, ack_d;

  logic                     found;
  logic [lg_lp-1:0]         pick;
  logic [addr_width_p-1:0]  pick_src;
  logic [addr_width_p-1:0]  pick_len;

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      int idx;
      idx = int'(last_q) + 1 + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && req_v_i[idx]) begin
        found = 1'b1;
        pick  = lg_lp'(idx);
      end
    end
    pick_src = req_src_addr_i[int'(pick)*addr_width_p +: addr_width_p];
    pick_len = req_len_i[int'(pick)*addr_width_p +: addr_width_p];
  end

  // Next-state and job-context update.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    src_d   = src_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d = pick;
          src_d = pick_src;
          len_d = pick_len;
          ack_d = num_req_p'(1) << pick;
          if (pick_len == '0) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = CFG_SRC;
            err_d   = 1'b0;
          end
        end
      end
      CFG_SRC: if (pkt_ready_i) state_d = CFG_LEN;
      CFG_LEN: if (pkt_ready_i) state_d = CFG_GO;
      CFG_GO: begin
        if (pkt_ready_i) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (accel_done_i) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (cnt_q == cnt_max_lp) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet, response and status outputs decoded from state.
  always_comb begin
    pkt_v_o    = 1'b0;
    pkt_addr_o = '0;
    pkt_data_o = '0;
    unique case (state_q)
      CFG_SRC: begin
        pkt_v_o    = 1'b1;
        pkt_addr_o = addr_width_p'(0);
        pkt_data_o = data_width_p'(src_q);
      end
      CFG_LEN: begin
        pkt_v_o    = 1'b1;
        pkt_addr_o = addr_width_p'(1);
        pkt_data_o = data_width_p'(len_q);
      end
      CFG_GO: begin
        pkt_v_o    = 1'b1;
        pkt_addr_o = addr_width_p'(2);
        pkt_data_o = data_width_p'(1);
      end
      default: ;
    endcase
    pkt_x_o    = pkt_v_o ? dest_x_i : '0;
    pkt_y_o    = pkt_v_o ? dest_y_i : '0;
    resp_v_o   = (state_q == DONE) ? (num_req_p'(1) << win_q) : '0;
    resp_err_o = (state_q == DONE) && err_q;
    busy_o     = (state_q != IDLE);
    req_ack_o  = ack_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= lg_lp'(num_req_p - 1);
      win_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      src_q   <= src_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: tb/tb_nn_accel_job_scheduler.sv
// Directed bench for nn_accel_job_scheduler.
// Scenario tasks run in sequence; timeout_p is 16 here.
module tb_nn_accel_job_scheduler;

  logic        clk;
  logic        reset_i;
  logic [3:0]  req_v_i;
  logic [39:0] req_src_addr_i;
  logic [39:0] req_len_i;
  logic [3:0]  req_ack_o;
  logic [1:0]  dest_x_i;
  logic [1:0]  dest_y_i;
  logic        pkt_v_o;
  logic        pkt_ready_i;
  logic [1:0]  pkt_x_o;
  logic [1:0]  pkt_y_o;
  logic [9:0]  pkt_addr_o;
  logic [31:0] pkt_data_o;
  logic        accel_done_i;
  logic [3:0]  resp_v_o;
  logic        resp_err_o;
  logic        busy_o;

  int checks = 0;
  int passed = 0;

  nn_accel_job_scheduler #(
    .num_req_p(4), .addr_width_p(10), .data_width_p(32),
    .x_cord_width_p(2), .y_cord_width_p(2), .timeout_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_src_addr_i(req_src_addr_i),
    .req_len_i(req_len_i), .req_ack_o(req_ack_o),
    .dest_x_i(dest_x_i), .dest_y_i(dest_y_i),
    .pkt_v_o(pkt_v_o), .pkt_ready_i(pkt_ready_i),
    .pkt_x_o(pkt_x_o), .pkt_y_o(pkt_y_o),
    .pkt_addr_o(pkt_addr_o), .pkt_data_o(pkt_data_o),
    .accel_done_i(accel_done_i), .resp_v_o(resp_v_o),
    .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    req_v_i = '0; req_src_addr_i = '0; req_len_i = '0;
    dest_x_i = 2'd2; dest_y_i = 2'd1;
    pkt_ready_i = 1'b1; accel_done_i = 1'b0;
    do_reset();
    checks++;
    if ({req_ack_o, pkt_v_o, resp_v_o, resp_err_o, busy_o} !== 11'd0)
      $display("FAIL reset_ctl got %b exp 0",
        {req_ack_o, pkt_v_o, resp_v_o, resp_err_o, busy_o});
    else passed++;
    checks++;
    if ({pkt_x_o, pkt_y_o, pkt_addr_o, pkt_data_o} !== 46'd0)
      $display("FAIL reset_pkt got %h exp 0",
        {pkt_x_o, pkt_y_o, pkt_addr_o, pkt_data_o});
    else passed++;
  endtask

  task automatic test_single_job();
    req_src_addr_i[9:0] = 10'h040;
    req_len_i[9:0]      = 10'h010;
    req_v_i = 4'b0001;
    step();
    checks++;
    if (req_ack_o !== 4'b0001)
      $display("FAIL single_ack got %b exp 0001", req_ack_o);
    else passed++;
    req_v_i = '0;
    checks++;
    if ({pkt_v_o, pkt_x_o, pkt_y_o, pkt_addr_o, pkt_data_o} !==
        {1'b1, 2'd2, 2'd1, 10'd0, 32'h40})
      $display("FAIL single_pkt0 got %b/%h/%h exp 1/0/40",
        pkt_v_o, pkt_addr_o, pkt_data_o);
    else passed++;
    step();
    checks++;
    if ({req_ack_o, pkt_v_o, pkt_addr_o, pkt_data_o} !==
        {4'b0, 1'b1, 10'd1, 32'h10})
      $display("FAIL single_pkt1 got %b/%b/%h/%h exp 0/1/1/10",
        req_ack_o, pkt_v_o, pkt_addr_o, pkt_data_o);
    else passed++;
    step();
    checks++;
    if ({pkt_v_o, pkt_addr_o, pkt_data_o} !== {1'b1, 10'd2, 32'h1})
      $display("FAIL single_pkt2 got %b/%h/%h exp 1/2/1",
        pkt_v_o, pkt_addr_o, pkt_data_o);
    else passed++;
    step();
    checks++;
    if ({pkt_v_o, busy_o, resp_v_o} !== {1'b0, 1'b1, 4'b0})
      $display("FAIL single_busy got %b/%b/%b exp 0/1/0000",
        pkt_v_o, busy_o, resp_v_o);
    else passed++;
    accel_done_i = 1'b1;
    step();
    accel_done_i = 1'b0;
    checks++;
    if ({resp_v_o, resp_err_o} !== {4'b0001, 1'b0})
      $display("FAIL single_resp got %b/%b exp 0001/0",
        resp_v_o, resp_err_o);
    else passed++;
    step();
    checks++;
    if ({resp_v_o, busy_o} !== 5'd0)
      $display("FAIL single_idle got %b/%b exp 0/0", resp_v_o, busy_o);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100,
                                  4'b1000, 4'b0001};
    logic [3:0] got;
    do_reset();
    req_len_i = {10'd4, 10'd3, 10'd2, 10'd1};
    req_v_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      got = '0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (|req_ack_o) begin
          got = req_ack_o;
          break;
        end
      end
      checks++;
      if (got !== exp_order[j])
        $display("FAIL rr_grant%0d got %b exp %b", j, got, exp_order[j]);
      else passed++;
      step();
      step();
      step();
      accel_done_i = 1'b1;
      step();
      accel_done_i = 1'b0;
      checks++;
      if (resp_v_o !== exp_order[j])
        $display("FAIL rr_resp%0d got %b exp %b", j, resp_v_o,
          exp_order[j]);
      else passed++;
      if (j == 4) req_v_i = '0;
      step();
    end
  endtask

  task automatic test_backpressure();
    req_src_addr_i[19:10] = 10'h123;
    req_len_i[19:10]      = 10'h055;
    req_v_i = 4'b0010;
    step();
    checks++;
    if (req_ack_o !== 4'b0010)
      $display("FAIL bp_ack got %b exp 0010", req_ack_o);
    else passed++;
    req_v_i = '0;
    step();
    pkt_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({pkt_v_o, pkt_addr_o, pkt_data_o} !== {1'b1, 10'd1, 32'h55})
        $display("FAIL bp_hold%0d got %b/%h/%h exp 1/1/55", k,
          pkt_v_o, pkt_addr_o, pkt_data_o);
      else passed++;
    end
    pkt_ready_i = 1'b1;
    step();
    checks++;
    if ({pkt_v_o, pkt_addr_o, pkt_data_o} !== {1'b1, 10'd2, 32'h1})
      $display("FAIL bp_go got %b/%h/%h exp 1/2/1",
        pkt_v_o, pkt_addr_o, pkt_data_o);
    else passed++;
    step();
    accel_done_i = 1'b1;
    step();
    accel_done_i = 1'b0;
    checks++;
    if ({resp_v_o, resp_err_o} !== {4'b0010, 1'b0})
      $display("FAIL bp_resp got %b/%b exp 0010/0", resp_v_o, resp_err_o);
    else passed++;
    step();
  endtask

  task automatic test_reset_in_busy();
    logic [3:0] seen;
    req_src_addr_i[29:20] = 10'h077;
    req_len_i[29:20]      = 10'h008;
    req_v_i = 4'b0100;
    step();
    req_v_i = '0;
    step();
    step();
    step();
    checks++;
    if ({busy_o, pkt_v_o} !== 2'b10)
      $display("FAIL rb_inbusy got %b/%b exp 1/0", busy_o, pkt_v_o);
    else passed++;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    checks++;
    if ({busy_o, resp_v_o} !== 5'd0)
      $display("FAIL rb_cleared got %b/%b exp 0/0", busy_o, resp_v_o);
    else passed++;
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen = seen | resp_v_o;
    end
    checks++;
    if (seen !== 4'b0)
      $display("FAIL rb_noresp got %b exp 0000", seen);
    else passed++;
    req_v_i = 4'b1111;
    step();
    req_v_i = '0;
    checks++;
    if (req_ack_o !== 4'b0001)
      $display("FAIL rb_regrant got %b exp 0001", req_ack_o);
    else passed++;
    step();
    step();
    step();
    accel_done_i = 1'b1;
    step();
    accel_done_i = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    req_src_addr_i[29:20] = 10'h007;
    req_len_i[29:20]      = 10'h003;
    req_v_i = 4'b0100;
    step();
    req_v_i = '0;
    step();
    accel_done_i = 1'b1;
    step();
    accel_done_i = 1'b0;
    step();
    for (int k = 0; k < 15; k++) step();
    checks++;
    if ({busy_o, resp_v_o} !== {1'b1, 4'b0})
      $display("FAIL to_early got %b/%b exp 1/0000", busy_o, resp_v_o);
    else passed++;
    step();
    checks++;
    if ({resp_v_o, resp_err_o} !== {4'b0100, 1'b1})
      $display("FAIL to_resp got %b/%b exp 0100/1", resp_v_o, resp_err_o);
    else passed++;
    step();
    checks++;
    if ({resp_v_o, busy_o} !== 5'd0)
      $display("FAIL to_idle got %b/%b exp 0/0", resp_v_o, busy_o);
    else passed++;
  endtask

  task automatic test_done_at_timeout();
    req_src_addr_i[39:30] = 10'h3ff;
    req_len_i[39:30]      = 10'h3ff;
    req_v_i = 4'b1000;
    step();
    req_v_i = '0;
    step();
    step();
    step();
    for (int k = 0; k < 15; k++) step();
    accel_done_i = 1'b1;
    step();
    accel_done_i = 1'b0;
    checks++;
    if ({resp_v_o, resp_err_o} !== {4'b1000, 1'b0})
      $display("FAIL dt_resp got %b/%b exp 1000/0", resp_v_o, resp_err_o);
    else passed++;
    step();
  endtask

  task automatic test_zero_length();
    logic pv_seen;
    req_len_i[9:0] = 10'd0;
    req_v_i = 4'b0001;
    step();
    req_v_i = '0;
    pv_seen = pkt_v_o;
    checks++;
    if ({req_ack_o, resp_v_o, resp_err_o} !== {4'b0001, 4'b0001, 1'b1})
      $display("FAIL zl_resp got %b/%b/%b exp 0001/0001/1",
        req_ack_o, resp_v_o, resp_err_o);
    else passed++;
    step();
    pv_seen = pv_seen | pkt_v_o;
    checks++;
    if ({pv_seen, busy_o, resp_v_o} !== 6'd0)
      $display("FAIL zl_nopkt got %b/%b/%b exp 0/0/0",
        pv_seen, busy_o, resp_v_o);
    else passed++;
  endtask

  initial begin
    reset_i = 1'b1;
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_reset_in_busy();
    test_timeout();
    test_done_at_timeout();
    test_zero_length();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
